// File: rtl/xb_level_sched.sv
// Level sequencer for the 2-channel polyphase wavelet bank: walks a LEVELS-deep Mallat
// decomposition of one frame, feeding sample pairs to the bank and emitting coefficients.
module xb_level_sched #(
    parameter int unsigned DW        = 16,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned LEVELS    = 4,
    parameter int unsigned WAIT_MAX  = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] src_data,
    input  logic          src_valid,
    output logic          src_ready,
    output logic [DW-1:0] xb_data,
    output logic          xb_wr,
    output logic          xb_vaild,
    input  logic          xb_ready,
    input  logic [DW-1:0] xb_h,
    input  logic [DW-1:0] xb_l,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_level,
    output logic          out_band,
    output logic          out_valid,
    input  logic          out_ack,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // The low-band buffer never holds more than FRAME_LEN/2 entries (level 1 input).
    localparam int unsigned AW    = (FRAME_LEN > 8) ? $clog2(FRAME_LEN / 2) : 2;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned WW    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

    typedef enum logic [3:0] {
        StIdle,
        StFetchE,
        StWrE,
        StFetchO,
        StWrO,
        StWaitRdy,
        StEmitH,
        StEmitL,
        StClear,
        StGuard,
        StDone
    } state_e;

    state_e        state_q;
    logic [1:0]    lvl_q;
    logic [AW-1:0] idx_q;
    logic [WW-1:0] wcnt_q;
    logic [DW-1:0] l_q;

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          mem_we;
    logic [31:0]   pairs_at_lvl;
    logic          more_pairs;
    logic          last_lvl;

    always_comb begin
        rd_addr      = {idx_q[AW-2:0], state_q == StFetchO};
        rd_data      = mem[rd_addr];
        pairs_at_lvl = (FRAME_LEN >> lvl_q) >> 1;
        more_pairs   = (32'(idx_q) + 32'd1) < pairs_at_lvl;
        last_lvl     = (32'(lvl_q) + 32'd1) == LEVELS;
        // Writing buf[idx] in place is safe: pair idx read buf[2*idx], buf[2*idx+1] already.
        mem_we       = (state_q == StEmitH) && out_valid && out_ack && !last_lvl;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= l_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            lvl_q     <= '0;
            idx_q     <= '0;
            wcnt_q    <= '0;
            l_q       <= '0;
            src_ready <= 1'b0;
            xb_data   <= '0;
            xb_wr     <= 1'b0;
            xb_vaild  <= 1'b0;
            out_data  <= '0;
            out_level <= '0;
            out_band  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StFetchE;
                        lvl_q     <= '0;
                        idx_q     <= '0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        src_ready <= 1'b1;
                    end
                end

                StFetchE, StFetchO: begin
                    if (lvl_q == 2'd0) begin
                        if (src_valid && src_ready) begin
                            xb_data   <= src_data;
                            xb_wr     <= 1'b1;
                            src_ready <= 1'b0;
                            state_q   <= (state_q == StFetchE) ? StWrE : StWrO;
                        end
                    end else begin
                        xb_data <= rd_data;
                        xb_wr   <= 1'b1;
                        state_q <= (state_q == StFetchE) ? StWrE : StWrO;
                    end
                end

                StWrE: begin
                    xb_wr     <= 1'b0;
                    src_ready <= (lvl_q == 2'd0);
                    state_q   <= StFetchO;
                end

                StWrO: begin
                    xb_wr   <= 1'b0;
                    wcnt_q  <= WW'(1);
                    state_q <= StWaitRdy;
                end

                // wcnt_q counts cycles spent here, including the current one.
                StWaitRdy: begin
                    if (xb_ready) begin
                        l_q       <= xb_l;
                        out_data  <= xb_h;
                        out_band  <= 1'b1;
                        out_level <= lvl_q;
                        out_valid <= 1'b1;
                        state_q   <= StEmitH;
                    end else if (wcnt_q == WW'(WAIT_MAX)) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end

                StEmitH: begin
                    if (out_ack) begin
                        out_valid <= 1'b0;
                        if (last_lvl) begin
                            out_data <= l_q;
                            out_band <= 1'b0;
                            state_q  <= StEmitL;
                        end else begin
                            xb_vaild <= 1'b1;
                            state_q  <= StClear;
                        end
                    end
                end

                // Valid drops for one cycle after the H handshake before L is offered.
                StEmitL: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ack) begin
                        out_valid <= 1'b0;
                        xb_vaild  <= 1'b1;
                        state_q   <= StClear;
                    end
                end

                StClear: begin
                    xb_vaild <= 1'b0;
                    state_q  <= StGuard;
                end

                // Bank ready lags the flag clear by a cycle, so it is not looked at here.
                StGuard: begin
                    if (more_pairs) begin
                        idx_q     <= idx_q + 1'b1;
                        src_ready <= (lvl_q == 2'd0);
                        state_q   <= StFetchE;
                    end else if (!last_lvl) begin
                        lvl_q   <= lvl_q + 2'd1;
                        idx_q   <= '0;
                        state_q <= StFetchE;
                    end else begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end

                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xb_level_sched.sv
// Scoreboard bench for xb_level_sched: two instances (8/1 and 16/4 frame/levels), a
// behavioural bank (L = even sample, H = odd sample) and a model of the expected outputs.
module tb_xb_level_sched;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  level;
        logic        band;
    } coef_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start     [2];
    logic [15:0] src_data  [2];
    logic        src_valid [2];
    logic        src_ready [2];
    logic [15:0] xb_data   [2];
    logic        xb_wr     [2];
    logic        xb_vaild  [2];
    logic        xb_ready  [2];
    logic [15:0] xb_h      [2];
    logic [15:0] xb_l      [2];
    logic [15:0] out_data  [2];
    logic [1:0]  out_level [2];
    logic        out_band  [2];
    logic        out_valid [2];
    logic        out_ack   [2];
    logic        busy      [2];
    logic        done      [2];
    logic        err       [2];

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    coef_t exp_q[$];

    logic [15:0] src_mem [2][16];
    bit          gap_mode = 1'b0;
    int          bank_dly   [2];
    bit          bank_never [2];
    int          sp         [2];
    int          src_taken  [2];
    int          wr_cnt     [2];
    int          done_cnt   [2];
    int          n_out      [2];
    int          wr_cyc     [2];
    int          done_cyc   [2];
    logic [18:0] last_out   [2];

    xb_level_sched #(.DW(16), .FRAME_LEN(8), .LEVELS(1), .WAIT_MAX(15)) u_dut_a (
        .clk(clk), .reset(reset), .start(start[0]),
        .src_data(src_data[0]), .src_valid(src_valid[0]), .src_ready(src_ready[0]),
        .xb_data(xb_data[0]), .xb_wr(xb_wr[0]), .xb_vaild(xb_vaild[0]),
        .xb_ready(xb_ready[0]), .xb_h(xb_h[0]), .xb_l(xb_l[0]),
        .out_data(out_data[0]), .out_level(out_level[0]), .out_band(out_band[0]),
        .out_valid(out_valid[0]), .out_ack(out_ack[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    xb_level_sched #(.DW(16), .FRAME_LEN(16), .LEVELS(4), .WAIT_MAX(15)) u_dut_b (
        .clk(clk), .reset(reset), .start(start[1]),
        .src_data(src_data[1]), .src_valid(src_valid[1]), .src_ready(src_ready[1]),
        .xb_data(xb_data[1]), .xb_wr(xb_wr[1]), .xb_vaild(xb_vaild[1]),
        .xb_ready(xb_ready[1]), .xb_h(xb_h[1]), .xb_l(xb_l[1]),
        .out_data(out_data[1]), .out_level(out_level[1]), .out_band(out_band[1]),
        .out_valid(out_valid[1]), .out_ack(out_ack[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int flen_of(input int g);
        return (g == 0) ? 8 : 16;
    endfunction

    task automatic load_src(input int g, input int base, input int step);
        for (int i = 0; i < 16; i++) src_mem[g][i] = 16'(base + i * step);
    endtask

    // Mallat reference: per pair H (odd) then, at the last level only, L (even).
    task automatic push_expected(input int g, input int levels);
        logic [15:0] cur [16];
        logic [15:0] nxt [16];
        int len;
        len = flen_of(g);
        for (int i = 0; i < 16; i++) cur[i] = src_mem[g][i];
        for (int k = 0; k < levels; k++) begin
            for (int i = 0; i < len / 2; i++) begin
                exp_q.push_back('{data: cur[2*i+1], level: 2'(k), band: 1'b1});
                if (k == levels - 1) exp_q.push_back('{data: cur[2*i], level: 2'(k), band: 1'b0});
                nxt[i] = cur[2*i];
            end
            for (int i = 0; i < len / 2; i++) cur[i] = nxt[i];
            len = len / 2;
        end
    endtask

    // Level-0 sample source; restarts when a start is accepted.
    initial begin : p_src
        logic take [2];
        logic st   [2];
        int   gap;
        gap = 0;
        for (int g = 0; g < 2; g++) begin
            src_valid[g] = 1'b0;
            src_data[g]  = '0;
            sp[g]        = 16;
            src_taken[g] = 0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                take[g] = src_valid[g] && src_ready[g];
                st[g]   = start[g] && !busy[g];
            end
            @(posedge clk);
            #1;
            gap++;
            for (int g = 0; g < 2; g++) begin
                if (st[g]) begin
                    sp[g] = 0;
                end else if (take[g]) begin
                    sp[g]++;
                    src_taken[g]++;
                end
                src_valid[g] = (sp[g] < flen_of(g)) && (!gap_mode || (gap % 3 == 0));
                src_data[g]  = (sp[g] < flen_of(g)) ? src_mem[g][sp[g]] : 16'h0;
            end
        end
    end

    // Behavioural bank: captures even/odd writes, raises ready bank_dly cycles later.
    initial begin : p_bank
        logic [15:0] ev   [2];
        logic [15:0] d    [2];
        logic        wr   [2];
        logic        clr  [2];
        int          half [2];
        int          cnt  [2];
        for (int g = 0; g < 2; g++) begin
            xb_ready[g] = 1'b0;
            xb_h[g]     = '0;
            xb_l[g]     = '0;
            ev[g]       = '0;
            half[g]     = 0;
            cnt[g]      = 0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                wr[g]  = xb_wr[g];
                clr[g] = xb_vaild[g];
                d[g]   = xb_data[g];
            end
            @(posedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                if (!reset) begin
                    half[g]     = 0;
                    cnt[g]      = 0;
                    xb_ready[g] = 1'b0;
                end else begin
                    if (clr[g]) xb_ready[g] = 1'b0;
                    if (wr[g]) begin
                        if (half[g] == 0) begin
                            ev[g]   = d[g];
                            half[g] = 1;
                        end else begin
                            xb_l[g] = ev[g];
                            xb_h[g] = d[g];
                            half[g] = 0;
                            cnt[g]  = bank_dly[g];
                        end
                    end else if (cnt[g] > 0) begin
                        cnt[g]--;
                        if (cnt[g] == 0 && !bank_never[g]) xb_ready[g] = 1'b1;
                    end
                end
            end
        end
    end

    // Output monitor: pops and compares one expected coefficient per handshake.
    initial begin : p_mon
        coef_t e;
        for (int g = 0; g < 2; g++) begin
            wr_cnt[g] = 0; done_cnt[g] = 0; n_out[g] = 0;
            wr_cyc[g] = 0; done_cyc[g] = 0; last_out[g] = '0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (xb_wr[g]) begin
                    wr_cnt[g]++;
                    wr_cyc[g] = cyc;
                end
                if (done[g]) begin
                    done_cnt[g]++;
                    done_cyc[g] = cyc;
                end
                if (out_valid[g] && out_ack[g]) begin
                    n_out[g]++;
                    last_out[g] = {out_data[g], out_level[g], out_band[g]};
                    if (exp_q.size() == 0) begin
                        check_eq("out_unexpected", 32'(n_out[g]), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("coef", 32'({out_data[g], out_level[g], out_band[g]}), 32'(e));
                    end
                end
            end
        end
    end

    task automatic start_frame(input int g);
        @(posedge clk);
        #1 start[g] = 1'b1;
        @(posedge clk);
        #1 start[g] = 1'b0;
        @(negedge clk);
        check_eq("busy_on_start", 32'(busy[g]), 32'd1);
        check_eq("err_clear_on_start", 32'(err[g]), 32'd0);
    endtask

    task automatic wait_frame(input int g, input int d0);
        int n;
        n = 0;
        while (done_cnt[g] == d0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check_eq("done_once", 32'(done_cnt[g] - d0), 32'd1);
        check_eq("busy_after", 32'(busy[g]), 32'd0);
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : p_main
        int d0, w0, o0, t0, n;
        logic [18:0] held;
        reset = 1'b1;
        for (int g = 0; g < 2; g++) begin
            start[g]      = 1'b0;
            out_ack[g]    = 1'b1;
            bank_dly[g]   = 3;
            bank_never[g] = 1'b0;
        end
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check_eq("rst_ctrl", 32'({busy[g], done[g], err[g], out_valid[g], src_ready[g],
                                      xb_wr[g], xb_vaild[g]}), 32'd0);
            check_eq("rst_data", 32'({out_data[g], xb_data[g]}), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;

        // 1: 8 samples, one level, bank ready 5 cycles after the odd write
        load_src(0, 1, 1);
        bank_dly[0] = 5;
        d0 = done_cnt[0]; w0 = wr_cnt[0]; o0 = n_out[0];
        push_expected(0, 1);
        start_frame(0);
        wait_frame(0, d0);
        check_eq("t1_outs", 32'(n_out[0] - o0), 32'd8);
        check_eq("t1_wrs", 32'(wr_cnt[0] - w0), 32'd8);

        // 2: 16 samples, four levels
        load_src(1, 5, 37);
        d0 = done_cnt[1]; w0 = wr_cnt[1]; o0 = n_out[1];
        push_expected(1, 4);
        start_frame(1);
        wait_frame(1, d0);
        check_eq("t2_outs", 32'(n_out[1] - o0), 32'd16);
        check_eq("t2_wrs", 32'(wr_cnt[1] - w0), 32'd30);
        check_eq("t2_last_l", 32'(last_out[1]), 32'({src_mem[1][0], 2'd3, 1'b0}));

        // 3: consumer stalls the first coefficient for 20 cycles
        load_src(1, 16'h0a00, 3);
        d0 = done_cnt[1];
        push_expected(1, 4);
        @(posedge clk);
        #1 out_ack[1] = 1'b0;
        start_frame(1);
        n = 0;
        while (!out_valid[1] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("t3_valid_seen", 32'(out_valid[1]), 32'd1);
        held = {out_data[1], out_level[1], out_band[1]};
        w0 = wr_cnt[1];
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("t3_hold", 32'({out_valid[1], out_data[1], out_level[1], out_band[1]}),
                     32'({1'b1, held}));
        end
        check_eq("t3_no_wr", 32'(wr_cnt[1] - w0), 32'd0);
        @(posedge clk);
        #1 out_ack[1] = 1'b1;
        wait_frame(1, d0);

        // 4: bank never ready -> timeout, then a clean frame clears err
        bank_never[0] = 1'b1;
        d0 = done_cnt[0]; o0 = n_out[0];
        start_frame(0);
        n = 0;
        while (done_cnt[0] == d0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("t4_done", 32'(done_cnt[0] - d0), 32'd1);
        check_eq("t4_wait_cycles", 32'(done_cyc[0] - wr_cyc[0]), 32'd16);
        @(negedge clk);
        check_eq("t4_err", 32'(err[0]), 32'd1);
        check_eq("t4_idle", 32'(busy[0]), 32'd0);
        check_eq("t4_no_out", 32'(n_out[0] - o0), 32'd0);
        bank_never[0] = 1'b0;
        bank_dly[0]   = 3;
        load_src(0, 16'h40, 1);
        d0 = done_cnt[0];
        push_expected(0, 1);
        start_frame(0);
        wait_frame(0, d0);
        check_eq("t4_err_stays_clear", 32'(err[0]), 32'd0);

        // 5a: start pulsed mid-frame is ignored
        load_src(1, 16'hc001, 11);
        d0 = done_cnt[1];
        push_expected(1, 4);
        start_frame(1);
        repeat (40) @(posedge clk);
        #1 start[1] = 1'b1;
        @(posedge clk);
        #1 start[1] = 1'b0;
        @(negedge clk);
        check_eq("t5_busy_kept", 32'({busy[1], err[1]}), 32'b10);
        wait_frame(1, d0);

        // 5b: reset during level 2 aborts the frame
        d0 = done_cnt[1];
        push_expected(1, 4);
        start_frame(1);
        n = 0;
        while (!(out_valid[1] && out_level[1] == 2'd2) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("t5_reached_lvl2", 32'(out_level[1]), 32'd2);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("t5_rst_ctrl", 32'({busy[1], done[1], err[1], out_valid[1], out_band[1],
                                     out_level[1], src_ready[1], xb_wr[1], xb_vaild[1]}), 32'd0);
        check_eq("t5_rst_data", 32'({out_data[1], xb_data[1]}), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("t5_stays_idle", 32'({busy[1], out_valid[1], src_ready[1]}), 32'd0);
        check_eq("t5_no_done", 32'(done_cnt[1] - d0), 32'd0);

        // 6: gapped source, same data as test 2
        load_src(1, 5, 37);
        gap_mode = 1'b1;
        d0 = done_cnt[1]; w0 = wr_cnt[1]; t0 = src_taken[1]; o0 = n_out[1];
        push_expected(1, 4);
        start_frame(1);
        wait_frame(1, d0);
        gap_mode = 1'b0;
        check_eq("t6_taken", 32'(src_taken[1] - t0), 32'd16);
        check_eq("t6_wrs", 32'(wr_cnt[1] - w0), 32'd30);
        check_eq("t6_outs", 32'(n_out[1] - o0), 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
